// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB arbiter in front of the UART completer.
// Holds the FSM state encoding, the requester index type and the requester count.
package apb_arb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned REQ_IDX_W = $clog2(NUM_REQ);

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/apb_uart_arbiter_if.sv
// Bundles the requester-side and completer-side APB signals of the arbiter.
// master: the arbiter's view; slave: the surrounding requesters and completer.
interface apb_uart_arbiter_if
    import apb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // requester side, one lane per requester
    logic [NUM_REQ-1:0]                 m_psel;
    logic [NUM_REQ-1:0]                 m_penable;
    logic [NUM_REQ-1:0]                 m_pwrite;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] m_paddr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] m_pwdata;
    logic [NUM_REQ-1:0][STRB_WIDTH-1:0] m_pstrb;
    logic [NUM_REQ-1:0]                 m_pready;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] m_prdata;
    logic [NUM_REQ-1:0]                 m_pslverr;

    // completer side
    logic                  s_psel;
    logic                  s_penable;
    logic                  s_pwrite;
    logic [ADDR_WIDTH-1:0] s_paddr;
    logic [DATA_WIDTH-1:0] s_pwdata;
    logic [STRB_WIDTH-1:0] s_pstrb;
    logic                  s_pready;
    logic                  s_pslverr;
    logic [DATA_WIDTH-1:0] s_prdata;

    modport master (
        input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb,
        output m_pready, m_prdata, m_pslverr,
        output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb,
        input  s_pready, s_pslverr, s_prdata
    );

    modport slave (
        output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb,
        input  m_pready, m_prdata, m_pslverr,
        input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb,
        output s_pready, s_pslverr, s_prdata
    );

endinterface

// File: rtl/apb_arb_rr_pick.sv
// Combinational round-robin pick between two requesters.
// A tie goes to whichever requester was not granted last.
module apb_arb_rr_pick
    import apb_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           last_grant,
    output req_idx_t           gnt_c,
    output logic               valid_c
);

    always_comb begin
        valid_c = |req;
        gnt_c   = req_idx_t'(0);
        if (&req) begin
            gnt_c = ~last_grant;
        end else if (req[1]) begin
            gnt_c = req_idx_t'(1);
        end
    end

endmodule

// File: rtl/apb_uart_arbiter.sv
// Two-requester APB arbiter sharing one APB UART completer: one transfer at a
// time, round-robin grants, and a wait-state watchdog that aborts a hung completer.
module apb_uart_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    apb_uart_arbiter_if.master bus
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam bit          WD_EN      = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CNT_W      = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned WD_LAST    = WD_EN ? TIMEOUT_CYCLES - 1 : 0;

    state_t                state_q, state_d;
    req_idx_t              grant_q, grant_d;
    req_idx_t              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  s_psel_q, s_psel_d;
    logic                  s_penable_q, s_penable_d;
    logic                  s_pwrite_q, s_pwrite_d;
    logic [ADDR_WIDTH-1:0] s_paddr_q, s_paddr_d;
    logic [DATA_WIDTH-1:0] s_pwdata_q, s_pwdata_d;
    logic [STRB_WIDTH-1:0] s_pstrb_q, s_pstrb_d;

    req_idx_t              pick_gnt;
    logic                  pick_valid;
    logic                  done_c;
    logic                  timeout_c;

    logic [NUM_REQ-1:0]                 m_pready_c;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] m_prdata_c;
    logic [NUM_REQ-1:0]                 m_pslverr_c;

    apb_arb_rr_pick u_pick (
        .req        (bus.m_psel),
        .last_grant (last_grant_q),
        .gnt_c      (pick_gnt),
        .valid_c    (pick_valid)
    );

    // State and completer-side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= req_idx_t'(0);
            last_grant_q <= req_idx_t'(1);
            cnt_q        <= '0;
            s_psel_q     <= 1'b0;
            s_penable_q  <= 1'b0;
            s_pwrite_q   <= 1'b0;
            s_paddr_q    <= '0;
            s_pwdata_q   <= '0;
            s_pstrb_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            s_psel_q     <= s_psel_d;
            s_penable_q  <= s_penable_d;
            s_pwrite_q   <= s_pwrite_d;
            s_paddr_q    <= s_paddr_d;
            s_pwdata_q   <= s_pwdata_d;
            s_pstrb_q    <= s_pstrb_d;
        end
    end

    // Next-state, grant latching and watchdog
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        s_psel_d     = s_psel_q;
        s_penable_d  = s_penable_q;
        s_pwrite_d   = s_pwrite_q;
        s_paddr_d    = s_paddr_q;
        s_pwdata_d   = s_pwdata_q;
        s_pstrb_d    = s_pstrb_q;
        done_c       = 1'b0;
        timeout_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick_gnt;
                    s_pwrite_d  = bus.m_pwrite[pick_gnt];
                    s_paddr_d   = bus.m_paddr[pick_gnt];
                    s_pwdata_d  = bus.m_pwdata[pick_gnt];
                    s_pstrb_d   = bus.m_pstrb[pick_gnt];
                    s_psel_d    = 1'b1;
                    s_penable_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                cnt_d       = '0;
                s_penable_d = 1'b1;
                state_d     = ACCESS;
            end
            ACCESS: begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // counter holds (ACCESS cycle number - 1); completer ready beats the watchdog
                if (bus.s_pready) begin
                    done_c = 1'b1;
                end else if (WD_EN && (cnt_q == CNT_W'(WD_LAST))) begin
                    done_c    = 1'b1;
                    timeout_c = 1'b1;
                end
                if (done_c) begin
                    last_grant_d = grant_q;
                    s_psel_d     = 1'b0;
                    s_penable_d  = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Completion response steered to the granted requester only
    always_comb begin
        m_pready_c  = '0;
        m_prdata_c  = '0;
        m_pslverr_c = '0;
        if (done_c && !rst) begin
            m_pready_c[grant_q]  = 1'b1;
            m_prdata_c[grant_q]  = timeout_c ? '0 : bus.s_prdata;
            m_pslverr_c[grant_q] = timeout_c ? 1'b1 : bus.s_pslverr;
        end
    end

    assign bus.m_pready  = m_pready_c;
    assign bus.m_prdata  = m_prdata_c;
    assign bus.m_pslverr = m_pslverr_c;

    assign bus.s_psel    = s_psel_q;
    assign bus.s_penable = s_penable_q;
    assign bus.s_pwrite  = s_pwrite_q;
    assign bus.s_paddr   = s_paddr_q;
    assign bus.s_pwdata  = s_pwdata_q;
    assign bus.s_pstrb   = s_pstrb_q;

endmodule
